// File: rtl/priority_dec_pkg.sv
// Shared types for the priority decoder: default width, skid FSM states and the stored entry.
package priority_dec_pkg;

    localparam int unsigned DEF_N_OUT = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Default-width view of one buffered token; the top builds its own width-matched slot.
    typedef struct packed {
        logic                 err;
        logic [DEF_N_OUT-1:0] vec;
    } entry_t;

endpackage

// File: rtl/priority_dec_if.sv
// Token-in / vector-out handshake bundle for priority_dec; slave is the decoder's view.
interface priority_dec_if #(
    parameter int unsigned N_OUT = priority_dec_pkg::DEF_N_OUT
);
    localparam int unsigned IDX_W = $clog2(N_OUT);

    logic             in_vld;
    logic             in_rdy;
    logic [IDX_W-1:0] in_idx;
    logic             in_nz;
    logic             out_vld;
    logic             out_rdy;
    logic [N_OUT-1:0] out_d;
    logic             out_err;

    modport master (
        output in_vld, in_idx, in_nz, out_rdy,
        input  in_rdy, out_vld, out_d, out_err
    );

    modport slave (
        input  in_vld, in_idx, in_nz, out_rdy,
        output in_rdy, out_vld, out_d, out_err
    );
endinterface

// File: rtl/prio_idx2vec.sv
// Combinational index -> request vector decode (index 0 = MSB).
// PRIORITY_DEC_THERM_EN selects thermometer fill instead of one-hot.
module prio_idx2vec #(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned IDX_W = $clog2(N_OUT)
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_nz,
    output logic [N_OUT-1:0] o_vec,
    output logic             o_err
);

    always_comb begin
        o_vec = '0;
        o_err = i_nz && (32'(i_idx) >= N_OUT);
        if (i_nz) begin
            for (int unsigned b = 0; b < N_OUT; b++) begin
`ifdef PRIORITY_DEC_THERM_EN
                // Fill from the indexed bit down to bit 0; out-of-range sets nothing.
                if (32'(i_idx) + b <= N_OUT - 1) begin
                    o_vec[b] = 1'b1;
                end
`else
                if (32'(i_idx) + b == N_OUT - 1) begin
                    o_vec[b] = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/priority_dec.sv
// Token-to-vector priority decoder with a 2-entry skid buffer (output reg A, skid reg B).
module priority_dec
    import priority_dec_pkg::*;
#(
    parameter int unsigned N_OUT = DEF_N_OUT
) (
    input  logic          clk,
    input  logic          rst,
    priority_dec_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N_OUT);

    typedef struct packed {
        logic             err;
        logic [N_OUT-1:0] vec;
    } slot_t;

    state_t           r_state;
    slot_t            r_a;
    slot_t            r_b;
    slot_t            w_dec;
    logic [N_OUT-1:0] w_dec_vec;
    logic             w_dec_err;
    logic             w_in_fire;
    logic             w_out_fire;

    prio_idx2vec #(
        .N_OUT (N_OUT),
        .IDX_W (IDX_W)
    ) u_idx2vec (
        .i_idx (bus.in_idx),
        .i_nz  (bus.in_nz),
        .o_vec (w_dec_vec),
        .o_err (w_dec_err)
    );

    assign w_dec = '{err: w_dec_err, vec: w_dec_vec};

    // Ready depends only on registered state, so backpressure never ripples upstream.
    assign bus.in_rdy  = (r_state != ST_FULL) & ~rst;
    assign bus.out_vld = (r_state != ST_EMPTY);
    assign bus.out_d   = r_a.vec;
    assign bus.out_err = r_a.err;

    assign w_in_fire  = bus.in_vld & bus.in_rdy;
    assign w_out_fire = bus.out_vld & bus.out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_a     <= w_dec;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_b     <= w_dec;
                        r_state <= ST_FULL;
                    end else if (w_in_fire && w_out_fire) begin
                        r_a <= w_dec;
                    end else if (w_out_fire) begin
                        r_a     <= '0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_a     <= r_b;
                        r_b     <= '0;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_dec.sv
// Directed bench for priority_dec: 4-bit DUT for the main flow, 5-bit DUT for the error case.
module tb_priority_dec;
    import priority_dec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    priority_dec_if #(.N_OUT(4)) bus4 ();
    priority_dec_if #(.N_OUT(5)) bus5 ();

    priority_dec #(.N_OUT(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    priority_dec #(.N_OUT(5)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-written expected 4-bit vectors for index k.
    function automatic logic [3:0] exp4(input int k);
`ifdef PRIORITY_DEC_THERM_EN
        case (k)
            0: return 4'b1111;
            1: return 4'b0111;
            2: return 4'b0011;
            default: return 4'b0001;
        endcase
`else
        case (k)
            0: return 4'b1000;
            1: return 4'b0100;
            2: return 4'b0010;
            default: return 4'b0001;
        endcase
`endif
    endfunction

    // Reference MSB-first encoder: {nz, y}.
    function automatic logic [2:0] enc4(input logic [3:0] d);
        logic [1:0] y;
        logic       nz;
        y  = 2'd0;
        nz = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (d[i] && !nz) begin
                y  = 2'(3 - i);
                nz = 1'b1;
            end
        end
        return {nz, y};
    endfunction

    initial begin
        int         seq [8];
        logic [3:0] d;
        logic [2:0] e_ref;
        logic [2:0] e_got;

        seq = '{3, 1, 0, 2, 1, 3, 0, 2};
        bus4.in_vld  = 1'b0;
        bus4.in_idx  = '0;
        bus4.in_nz   = 1'b0;
        bus4.out_rdy = 1'b1;
        bus5.in_vld  = 1'b0;
        bus5.in_idx  = '0;
        bus5.in_nz   = 1'b0;
        bus5.out_rdy = 1'b1;

        // Reset state
        step();
        step();
        check("rst_vld", 32'(bus4.out_vld), 32'd0);
        check("rst_d", 32'(bus4.out_d), 32'd0);
        check("rst_err", 32'(bus4.out_err), 32'd0);
        check("rst_rdy", 32'(bus4.in_rdy), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_rdy", 32'(bus4.in_rdy), 32'd1);
        check("post_rst_vld", 32'(bus4.out_vld), 32'd0);

        // Sweep with out_rdy held high
        bus4.in_vld = 1'b1;
        bus4.in_nz  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus4.in_idx = 2'(k);
            step();
            check($sformatf("sweep_vld%0d", k), 32'(bus4.out_vld), 32'd1);
            check($sformatf("sweep_d%0d", k), 32'(bus4.out_d), 32'(exp4(k)));
            check($sformatf("sweep_rdy%0d", k), 32'(bus4.in_rdy), 32'd1);
        end
        bus4.in_nz  = 1'b0;
        bus4.in_idx = 2'd2;
        step();
        check("sweep_zero_vld", 32'(bus4.out_vld), 32'd1);
        check("sweep_zero_d", 32'(bus4.out_d), 32'd0);
        check("sweep_zero_err", 32'(bus4.out_err), 32'd0);
        bus4.in_vld = 1'b0;
        step();
        check("sweep_drain", 32'(bus4.out_vld), 32'd0);

        // Backpressure: fill both entries, then drain in order
        bus4.out_rdy = 1'b0;
        bus4.in_vld  = 1'b1;
        bus4.in_nz   = 1'b1;
        bus4.in_idx  = 2'd2;
        step();
        check("bp_first_d", 32'(bus4.out_d), 32'(exp4(2)));
        check("bp_first_rdy", 32'(bus4.in_rdy), 32'd1);
        bus4.in_idx = 2'd0;
        step();
        check("bp_full_rdy", 32'(bus4.in_rdy), 32'd0);
        check("bp_hold_d", 32'(bus4.out_d), 32'(exp4(2)));
        bus4.in_vld = 1'b0;
        step();
        check("bp_stable_d", 32'(bus4.out_d), 32'(exp4(2)));
        check("bp_stable_vld", 32'(bus4.out_vld), 32'd1);
        bus4.out_rdy = 1'b1;
        step();
        check("bp_second_d", 32'(bus4.out_d), 32'(exp4(0)));
        check("bp_second_vld", 32'(bus4.out_vld), 32'd1);
        check("bp_rdy_back", 32'(bus4.in_rdy), 32'd1);
        step();
        check("bp_empty", 32'(bus4.out_vld), 32'd0);

        // Simultaneous in/out fire: stays in ST_ONE, no stall
        bus4.in_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus4.in_idx = 2'(seq[i]);
            step();
            check($sformatf("sim_d%0d", i), 32'(bus4.out_d), 32'(exp4(seq[i])));
            check($sformatf("sim_rdy%0d", i), 32'(bus4.in_rdy), 32'd1);
            check($sformatf("sim_st%0d", i), 32'(u_dut4.r_state), 32'(ST_ONE));
        end
        bus4.in_vld = 1'b0;
        step();
        check("sim_drain", 32'(bus4.out_vld), 32'd0);

        // Asynchronous reset with two tokens buffered
        bus4.out_rdy = 1'b0;
        bus4.in_vld  = 1'b1;
        bus4.in_idx  = 2'd1;
        step();
        bus4.in_idx = 2'd3;
        step();
        check("mid_full_rdy", 32'(bus4.in_rdy), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 32'(bus4.out_vld), 32'd0);
        check("mid_rst_d", 32'(bus4.out_d), 32'd0);
        check("mid_rst_rdy", 32'(bus4.in_rdy), 32'd0);
        bus4.out_rdy = 1'b1;
        step();
        check("mid_rst_edge_vld", 32'(bus4.out_vld), 32'd0);
        bus4.in_vld = 1'b0;
        rst = 1'b0;
        step();
        check("mid_rel_rdy", 32'(bus4.in_rdy), 32'd1);
        check("mid_rel_vld", 32'(bus4.out_vld), 32'd0);

        // Out-of-range index on the 5-wide decoder
        bus5.in_vld = 1'b1;
        bus5.in_nz  = 1'b1;
        bus5.in_idx = 3'd6;
        step();
        check("err_vld", 32'(bus5.out_vld), 32'd1);
        check("err_d", 32'(bus5.out_d), 32'd0);
        check("err_flag", 32'(bus5.out_err), 32'd1);
        bus5.in_idx = 3'd0;
        step();
`ifdef PRIORITY_DEC_THERM_EN
        check("err_next_d", 32'(bus5.out_d), 32'h1f);
`else
        check("err_next_d", 32'(bus5.out_d), 32'h10);
`endif
        check("err_next_flag", 32'(bus5.out_err), 32'd0);
        bus5.in_idx = 3'd4;
        step();
        check("n5_lsb_d", 32'(bus5.out_d), 32'h01);
        check("n5_lsb_flag", 32'(bus5.out_err), 32'd0);
        bus5.in_vld = 1'b0;
        step();

        // Round trip through the reference encoder
        bus4.in_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d           = 4'($urandom);
            e_ref       = enc4(d);
            bus4.in_nz  = e_ref[2];
            bus4.in_idx = e_ref[1:0];
            step();
            e_got = enc4(bus4.out_d);
            check($sformatf("rt_vld%0d", i), 32'(bus4.out_vld), 32'd1);
            check($sformatf("rt_nz%0d", i), 32'(e_got[2]), 32'(d != 4'd0));
            if (e_ref[2]) begin
                check($sformatf("rt_y%0d", i), 32'(e_got[1:0]), 32'(e_ref[1:0]));
            end
        end
        bus4.in_vld = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
